// File: rtl/mem_port_ctrl.sv
// Data-memory port arbiter between the pipeline and the block-transfer unit.
// Handles byte/half/word lane steering, load extraction and misalignment.
`ifndef CPU_DMEM_ADDR_WIDTH
`define CPU_DMEM_ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_port_ctrl #(
    parameter int AW = `CPU_DMEM_ADDR_WIDTH,
    parameter int DW = `DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] p_addr,
    input  logic [DW-1:0] p_wdata,
    input  logic          p_rd,
    input  logic          p_wr,
    input  logic [1:0]    p_size,
    input  logic          p_signed,
    output logic [DW-1:0] p_rdata,
    output logic          p_rvalid,
    output logic          p_stall,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    input  logic          b_rd,
    input  logic          b_wr,
    input  logic [1:0]    b_size,
    input  logic          b_busy,
    output logic [DW-1:0] b_rdata,
    output logic          b_rvalid,
    output logic [AW-3:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [3:0]    m_we,
    output logic          m_en,
    input  logic [DW-1:0] m_rdata,
    output logic          misalign
);

    typedef enum logic [1:0] {
        S_PIPE  = 2'd0,
        S_BDTU  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          b_grant, p_grant;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [1:0]    sel_size;
    logic          sel_rd, sel_wr, sel_signed;
    logic          misaligned, req, mem_go, rd_accept;
    logic [3:0]    lanes;

    logic          rd_valid_q, rd_valid_d;
    logic          owner_b_q, owner_b_d;
    logic          signed_q, signed_d;
    logic          misalign_q, misalign_d;
    logic [1:0]    size_q, size_d;
    logic [1:0]    off_q, off_d;

    logic [7:0]    byte_lane;
    logic [15:0]   half_lane;
    logic [DW-1:0] rd_ext;

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_PIPE;
            rd_valid_q <= 1'b0;
            owner_b_q  <= 1'b0;
            signed_q   <= 1'b0;
            misalign_q <= 1'b0;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_valid_d;
            owner_b_q  <= owner_b_d;
            signed_q   <= signed_d;
            misalign_q <= misalign_d;
            size_q     <= size_d;
            off_q      <= off_d;
        end
    end

    // A read accepted this cycle also counts as outstanding so its response drains.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_PIPE:  if (b_busy) state_d = S_BDTU;
            S_BDTU:  if (!b_busy) state_d = (rd_valid_q | rd_accept) ? S_DRAIN : S_PIPE;
            S_DRAIN: state_d = S_PIPE;
            default: state_d = S_PIPE;
        endcase
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        b_grant    = (state_q == S_BDTU) | b_busy;
        p_grant    = ~b_grant & (state_q == S_PIPE);
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_size   = 2'b00;
        sel_rd     = 1'b0;
        sel_wr     = 1'b0;
        sel_signed = 1'b0;
        if (b_grant) begin
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
            sel_size  = b_size;
            sel_rd    = b_rd;
            sel_wr    = b_wr;
        end else if (p_grant) begin
            sel_addr   = p_addr;
            sel_wdata  = p_wdata;
            sel_size   = p_size;
            sel_rd     = p_rd;
            sel_wr     = p_wr;
            sel_signed = p_signed;
        end
        p_stall = (p_rd | p_wr) & ~p_grant;
    end

    always_comb begin
        misaligned = ((sel_size == 2'b01) & sel_addr[0]) |
                     (sel_size[1] & (sel_addr[1:0] != 2'b00));
        req        = sel_rd | sel_wr;
        mem_go     = req & ~misaligned & rst_n;
        rd_accept  = mem_go & sel_rd & ~sel_wr;
        m_addr     = sel_addr[AW-1:2];
        m_en       = mem_go;
        m_we       = 4'b0000;
        m_wdata    = sel_wdata;
        lanes      = 4'b1111;
        unique case (sel_size)
            2'b00: begin
                m_wdata = {4{sel_wdata[7:0]}};
                lanes   = 4'b0001 << sel_addr[1:0];
            end
            2'b01: begin
                m_wdata = {2{sel_wdata[15:0]}};
                lanes   = sel_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        if (mem_go & sel_wr) m_we = lanes;
        misalign_d = misalign_q | (req & misaligned);
    end

    // Response context is captured at acceptance so it survives a grant change.
    always_comb begin
        rd_valid_d = rd_accept;
        owner_b_d  = owner_b_q;
        size_d     = size_q;
        off_d      = off_q;
        signed_d   = signed_q;
        if (rd_accept) begin
            owner_b_d = b_grant;
            size_d    = sel_size;
            off_d     = sel_addr[1:0];
            signed_d  = sel_signed;
        end
    end

    always_comb begin
        unique case (off_q)
            2'd0:    byte_lane = m_rdata[7:0];
            2'd1:    byte_lane = m_rdata[15:8];
            2'd2:    byte_lane = m_rdata[23:16];
            default: byte_lane = m_rdata[31:24];
        endcase
        half_lane = off_q[1] ? m_rdata[31:16] : m_rdata[15:0];
        unique case (size_q)
            2'b00:   rd_ext = {{(DW-8){signed_q & byte_lane[7]}}, byte_lane};
            2'b01:   rd_ext = {{(DW-16){signed_q & half_lane[15]}}, half_lane};
            default: rd_ext = m_rdata;
        endcase
        p_rvalid = rd_valid_q & ~owner_b_q;
        b_rvalid = rd_valid_q & owner_b_q;
        p_rdata  = p_rvalid ? rd_ext : '0;
        b_rdata  = b_rvalid ? rd_ext : '0;
        misalign = misalign_q;
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Scoreboard bench for mem_port_ctrl: expected load responses are queued at
// issue time and compared when the response cycle arrives.
module tb_mem_port_ctrl;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] p_addr, b_addr;
    logic [DW-1:0] p_wdata, b_wdata;
    logic          p_rd, p_wr, p_signed, b_rd, b_wr, b_busy;
    logic [1:0]    p_size, b_size;
    logic [DW-1:0] p_rdata, b_rdata, m_wdata;
    logic          p_rvalid, p_stall, b_rvalid, m_en, misalign;
    logic [AW-3:0] m_addr;
    logic [3:0]    m_we;
    logic [DW-1:0] m_rdata = '0;

    typedef struct {
        bit          owner_b;
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t exp_q[$];
    int   cyc;
    int   n_vec;
    int   n_miss;

    always #5 clk = ~clk;

    mem_port_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_addr(p_addr), .p_wdata(p_wdata), .p_rd(p_rd), .p_wr(p_wr),
        .p_size(p_size), .p_signed(p_signed), .p_rdata(p_rdata),
        .p_rvalid(p_rvalid), .p_stall(p_stall),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_rd(b_rd), .b_wr(b_wr),
        .b_size(b_size), .b_busy(b_busy), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_en(m_en),
        .m_rdata(m_rdata), .misalign(misalign)
    );

    function automatic logic [31:0] word_at(input logic [AW-3:0] w);
        if (w == 14'h40) return 32'h8001_1234;
        return {~w[7:0], 8'h81, w[7:0], 8'h7E};
    endfunction

    // Synchronous-read memory with one cycle of latency.
    always @(posedge clk) if (m_en) m_rdata <= word_at(m_addr);

    function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> (8 * off));
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return sgn ? {{24{b[7]}}, b} : {24'h0, b};
            2'b01:   return sgn ? {{16{h[15]}}, h} : {16'h0, h};
            default: return word;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic edge_only();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_rsp();
        rsp_t r;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r = exp_q.pop_front();
            check("p_rvalid", 32'(p_rvalid), 32'(!r.owner_b));
            check("b_rvalid", 32'(b_rvalid), 32'(r.owner_b));
            check("p_rdata", p_rdata, r.owner_b ? 32'h0 : r.data);
            check("b_rdata", b_rdata, r.owner_b ? r.data : 32'h0);
        end else begin
            check("p_rvalid_idle", 32'(p_rvalid), 32'h0);
            check("b_rvalid_idle", 32'(b_rvalid), 32'h0);
            check("p_rdata_idle", p_rdata, 32'h0);
            check("b_rdata_idle", b_rdata, 32'h0);
        end
    endtask

    task automatic step();
        edge_only();
        check_rsp();
    endtask

    task automatic idle();
        p_rd = 0; p_wr = 0; b_rd = 0; b_wr = 0;
    endtask

    task automatic push(input bit owner_b, input logic [AW-1:0] addr, input logic [1:0] size,
                        input logic sgn);
        rsp_t r;
        r.owner_b = owner_b;
        r.data    = exp_load(word_at(addr[AW-1:2]), size, addr[1:0], sgn);
        r.due     = cyc + 1;
        exp_q.push_back(r);
    endtask

    task automatic pipe_load(input logic [AW-1:0] addr, input logic [1:0] size, input logic sgn);
        p_addr = addr; p_size = size; p_signed = sgn; p_rd = 1; p_wr = 0;
        push(0, addr, size, sgn);
    endtask

    task automatic bdtu_load(input logic [AW-1:0] addr);
        b_addr = addr; b_size = 2'b10; b_rd = 1; b_wr = 0;
        push(1, addr, 2'b10, 1'b0);
    endtask

    initial begin
        n_vec = 0; n_miss = 0; cyc = 0;
        rst_n = 0; b_busy = 0;
        p_addr = '0; p_wdata = 32'hFFFF_FFFF; p_size = 2'b10; p_signed = 0;
        b_addr = '0; b_wdata = 32'hFFFF_FFFF; b_size = 2'b10;
        p_rd = 1; p_wr = 1; b_rd = 1; b_wr = 1;
        #2;
        check("rst_m_we", 32'(m_we), 32'h0);
        check("rst_m_en", 32'(m_en), 32'h0);
        check("rst_misalign", 32'(misalign), 32'h0);
        check("rst_p_rvalid", 32'(p_rvalid), 32'h0);
        check("rst_b_rdata", b_rdata, 32'h0);
        @(posedge clk); #1;
        idle();
        rst_n = 1;

        // Pipeline byte store to 0x103.
        p_addr = 16'h0103; p_wdata = 32'h0000_00AB; p_size = 2'b00; p_wr = 1;
        #1;
        check("bst_m_addr", 32'(m_addr), 32'h40);
        check("bst_m_we", 32'(m_we), 32'b1000);
        check("bst_m_wdata", m_wdata, 32'hABAB_ABAB);
        check("bst_m_en", 32'(m_en), 32'h1);
        check("bst_stall", 32'(p_stall), 32'h0);
        step();

        // Half store to the upper half of word 0x40.
        p_addr = 16'h0102; p_wdata = 32'h1234_CDEF; p_size = 2'b01; p_wr = 1;
        #1;
        check("hst_m_we", 32'(m_we), 32'b1100);
        check("hst_m_wdata", m_wdata, 32'hCDEF_CDEF);
        step();

        // Back-to-back loads of assorted size, lane and signedness.
        idle(); pipe_load(16'h0102, 2'b01, 1'b1); step();
        idle(); pipe_load(16'h0101, 2'b00, 1'b0); step();
        idle(); pipe_load(16'h0103, 2'b00, 1'b1); step();
        idle(); pipe_load(16'h0100, 2'b10, 1'b0); step();
        idle(); pipe_load(16'h0100, 2'b01, 1'b1); step();
        idle(); pipe_load(16'h0155, 2'b00, 1'b0); step();

        // Read together with write is a write only: no response follows.
        idle(); p_addr = 16'h0100; p_size = 2'b10; p_wdata = 32'h1357_9BDF; p_rd = 1; p_wr = 1;
        #1;
        check("rw_m_we", 32'(m_we), 32'hF);
        check("rw_m_wdata", m_wdata, 32'h1357_9BDF);
        step();
        idle(); step();

        // Block-transfer burst of three word loads while the pipeline waits.
        p_addr = 16'h0200; p_size = 2'b10; p_signed = 0; p_rd = 1;
        b_busy = 1;
        for (int i = 0; i < 3; i++) begin
            bdtu_load(16'(16'h0010 + 4 * i));
            #1;
            check("burst_stall", 32'(p_stall), 32'h1);
            check("burst_m_addr", 32'(m_addr), 32'(4 + i));
            check("burst_m_en", 32'(m_en), 32'h1);
            step();
        end
        b_busy = 0; b_rd = 0;
        #1;
        check("burst_tail_stall", 32'(p_stall), 32'h1);
        step();
        check("drain_stall", 32'(p_stall), 32'h1);
        check("drain_m_en", 32'(m_en), 32'h0);
        step();
        check("after_drain_stall", 32'(p_stall), 32'h0);
        pipe_load(16'h0200, 2'b10, 1'b0);
        step();

        // Pipeline response survives the hand-over of the port.
        idle(); pipe_load(16'h0100, 2'b10, 1'b0);
        edge_only();
        idle(); b_busy = 1; bdtu_load(16'h0020);
        #1;
        check_rsp();
        step();
        b_rd = 0; b_wr = 1; b_size = 2'b01; b_addr = 16'h0022; b_wdata = 32'h0000_BEEF;
        #1;
        check("b_hst_m_we", 32'(m_we), 32'b1100);
        check("b_hst_m_wdata", m_wdata, 32'hBEEF_BEEF);
        step();
        // No read pending: straight back to the pipeline without draining.
        b_busy = 0; b_wr = 0; p_addr = 16'h0104; p_size = 2'b10; p_rd = 1;
        #1;
        check("hand_back_stall", 32'(p_stall), 32'h1);
        step();
        check("no_drain_stall", 32'(p_stall), 32'h0);
        pipe_load(16'h0104, 2'b10, 1'b0);
        step();

        // Misaligned accesses are blocked and flagged stickily.
        idle(); p_addr = 16'h0006; p_size = 2'b10; p_wdata = 32'h1111_2222; p_wr = 1;
        #1;
        check("mis_m_we", 32'(m_we), 32'h0);
        check("mis_m_en", 32'(m_en), 32'h0);
        check("mis_before", 32'(misalign), 32'h0);
        step();
        check("mis_set", 32'(misalign), 32'h1);
        idle(); p_addr = 16'h0101; p_size = 2'b01; p_rd = 1;
        #1;
        check("mis_half_m_en", 32'(m_en), 32'h0);
        step();
        idle(); step();
        check("mis_held", 32'(misalign), 32'h1);

        // Reset pulse in S_BDTU with a block read outstanding.
        b_busy = 1; bdtu_load(16'h0030);
        edge_only();
        rst_n = 0; b_busy = 0; b_rd = 0;
        exp_q.delete();
        #1;
        check("rst_mid_b_rvalid", 32'(b_rvalid), 32'h0);
        check("rst_mid_b_rdata", b_rdata, 32'h0);
        check("rst_mid_stall", 32'(p_stall), 32'h0);
        check("rst_mid_misalign", 32'(misalign), 32'h0);
        p_addr = 16'h0108; p_size = 2'b10; p_signed = 0; p_rd = 1;
        #1;
        check("rst_req_m_en", 32'(m_en), 32'h0);
        rst_n = 1;
        #1;
        check("post_rst_stall", 32'(p_stall), 32'h0);
        check("post_rst_m_en", 32'(m_en), 32'h1);
        pipe_load(16'h0108, 2'b10, 1'b0);
        step();
        idle(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
